demux_stream_nch: RTL

//  Registered, flow-controlled 1-to-CH demultiplexer for N-bit data words.
//  - Each accepted input word is steered by in_sel into one of CH per-channel FIFOs (DEPTH entries each).
//  - Each channel drains independently through its own valid/ready port.
//  - Sits between a single producer (e.g. a decoder front end) and CH independent consumers.
//  - Successor to the combinational 4-way N-bit demux: channel count is parametrised; buffering and backpressure are added.

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_chan_fifo.sv | 52 +++++
 rtl/demux_stream_nch.sv | 81 ++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the flow-controlled stream demultiplexer.
package demux_pkg;

  localparam int DEF_N     = 8;
  localparam int DEF_CH    = 4;
  localparam int DEF_DEPTH = 2;

  // Like $clog2, but never returns 0, so a derived vector is at least 1 bit wide.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slice_lo(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-channel FIFO: registered output, no fall-through, storage not reset.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] wdata,
  output logic         full,
  input  logic         pop,
  output logic [N-1:0] rdata,
  output logic         valid
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign valid     = (r_count != '0);
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && valid;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/demux_stream_nch.sv
// 1-to-CH registered demultiplexer with a small FIFO per output channel.
module demux_stream_nch
  import demux_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CH    = DEF_CH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int SW   = clog2_min1(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_data,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [CH*N-1:0] out_data,
  output logic [CH-1:0]   out_valid,
  input  logic [CH-1:0]   out_ready,
  output logic            err_sel,
  input  logic            clr_err
);

  // Handshake: a word moves when valid & ready are both high at a rising edge;
  // the offering side holds its payload stable until that edge.

  logic [CH-1:0] w_push;
  logic [CH-1:0] w_full;
  logic [CH-1:0] w_valid;
  logic [N-1:0]  w_rdata [CH];
  logic          w_sel_ok;
  logic          w_drop;
  logic          r_err;

  assign w_sel_ok = (int'(in_sel) < CH);
  assign w_drop   = in_valid && !w_sel_ok;

  // in_ready looks only at the selected channel's full flag, never at out_ready.
  always_comb begin
    in_ready = 1'b1;
    for (int k = 0; k < CH; k++) begin
      if (int'(in_sel) == k) in_ready = !w_full[k];
    end
  end

  always_comb begin
    w_push = '0;
    for (int k = 0; k < CH; k++) begin
      w_push[k] = in_valid && (int'(in_sel) == k) && !w_full[k];
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    demux_chan_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push[g]),
      .wdata (in_data),
      .full  (w_full[g]),
      .pop   (out_ready[g]),
      .rdata (w_rdata[g]),
      .valid (w_valid[g])
    );

    assign out_data[slice_lo(g, N) +: N] = w_valid[g] ? w_rdata[g] : '0;
  end

  assign out_valid = w_valid;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_err <= 1'b0;
    else if (w_drop)  r_err <= 1'b1;
    else if (clr_err) r_err <= 1'b0;
  end

  assign err_sel = r_err;

endmodule
